// File: rtl/dff_reg_arbiter_pkg.sv
// rtl/dff_reg_arbiter_pkg.sv - shared constants and state type for the register arbiter
package dff_reg_arbiter_pkg;

    localparam int W_DEF    = 8;
    localparam int HOLD_DEF = 2;
    localparam int HOLD_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ACK  = ST_ACK,
        S_LOCK = ST_LOCK
    } state_t;

endpackage

// File: rtl/dff_reg_w.sv
// rtl/dff_reg_w.sv - W-bit D register with synchronous active-high reset and load enable
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset, clears q_o
//   en_i   load enable
//   d_i    data loaded when en_i is high
//   q_o    register contents
module dff_reg_w #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// rtl/dff_reg_arbiter.sv - two-requester round-robin arbiter sequencing writes to a shared register
// Ports:
//   C          clock, rising edge
//   R          synchronous active-high reset
//   REQ0, D0   request and write data, requester 0
//   REQ1, D1   request and write data, requester 1
//   ACK0/ACK1  registered one-cycle grant pulses
//   Q          shared register contents
//   LAST       requester index of the most recent write
//   BUSY       high while acknowledging or locked
module dff_reg_arbiter
    import dff_reg_arbiter_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int HOLD = HOLD_DEF
) (
    input  logic         C,
    input  logic         R,
    input  logic         REQ0,
    input  logic [W-1:0] D0,
    input  logic         REQ1,
    input  logic [W-1:0] D1,
    output logic         ACK0,
    output logic         ACK1,
    output logic [W-1:0] Q,
    output logic         LAST,
    output logic         BUSY
);

    // Counter reload: LOCK spans HOLD cycles, counting HOLD-1 down to 0.
    localparam logic [HOLD_W-1:0] HOLD_M1 = (HOLD == 0) ? '0 : HOLD_W'(HOLD - 1);

    state_t              state_q, state_d;
    logic                pri_q, pri_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                load;
    logic                win;
    logic [W-1:0]        din;

    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        cnt_d   = cnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        last_d  = last_q;
        busy_d  = busy_q;
        load    = 1'b0;
        win     = 1'b0;
        din     = D0;

        case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    // Contention goes to the pointer; otherwise the sole requester wins.
                    win     = (REQ0 && REQ1) ? pri_q : REQ1;
                    din     = win ? D1 : D0;
                    load    = 1'b1;
                    last_d  = win;
                    pri_d   = ~win;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    busy_d  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (HOLD == 0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_LOCK;
                    cnt_d   = HOLD_M1;
                end
            end
            S_LOCK: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= S_IDLE;
            pri_q   <= 1'b0;
            cnt_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            cnt_q   <= cnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    dff_reg_w #(.W(W)) u_reg (
        .clk_i (C),
        .rst_i (R),
        .en_i  (load),
        .d_i   (din),
        .q_o   (Q)
    );

    assign ACK0 = ack0_q;
    assign ACK1 = ack1_q;
    assign LAST = last_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb/tb_dff_reg_arbiter.sv - scoreboard bench for dff_reg_arbiter with HOLD=2 and HOLD=0 instances
module tb_dff_reg_arbiter;

    typedef struct packed {
        logic       idx;
        logic [7:0] q;
    } exp_t;

    logic       C;
    logic       R, REQ0, REQ1, ACK0, ACK1, LAST, BUSY;
    logic [7:0] D0, D1, Q;
    logic       R_h, REQ0_h, REQ1_h, ACK0_h, ACK1_h, LAST_h, BUSY_h;
    logic [7:0] D0_h, D1_h, Q_h;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    dff_reg_arbiter #(.W(8), .HOLD(2)) u_dut (
        .C(C), .R(R), .REQ0(REQ0), .D0(D0), .REQ1(REQ1), .D1(D1),
        .ACK0(ACK0), .ACK1(ACK1), .Q(Q), .LAST(LAST), .BUSY(BUSY)
    );

    dff_reg_arbiter #(.W(8), .HOLD(0)) u_dut_h0 (
        .C(C), .R(R_h), .REQ0(REQ0_h), .D0(D0_h), .REQ1(REQ1_h), .D1(D1_h),
        .ACK0(ACK0_h), .ACK1(ACK1_h), .Q(Q_h), .LAST(LAST_h), .BUSY(BUSY_h)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge C);
    endtask

    task automatic reset0();
        R = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
        tick(); tick();
        R = 1'b0;
    endtask

    // Monitors: every ACK pops one expected grant and compares index, data and LAST.
    always @(negedge C) begin
        if (ACK0 && ACK1) check("h2_ack_overlap", 1, 0);
        if (ACK0 || ACK1) begin
            if (q0.size() == 0) begin
                check("h2_unexpected_ack", {ACK1, ACK0}, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("h2_ack_idx", ACK1, e.idx);
                check("h2_ack_q", Q, e.q);
                check("h2_ack_last", LAST, e.idx);
            end
        end
    end

    always @(negedge C) begin
        if (ACK0_h && ACK1_h) check("h0_ack_overlap", 1, 0);
        if (ACK0_h || ACK1_h) begin
            if (q1.size() == 0) begin
                check("h0_unexpected_ack", {ACK1_h, ACK0_h}, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("h0_ack_idx", ACK1_h, e.idx);
                check("h0_ack_q", Q_h, e.q);
                check("h0_ack_last", LAST_h, e.idx);
            end
        end
    end

    initial begin
        R = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; D0 = 8'h00; D1 = 8'h00;
        R_h = 1'b1; REQ0_h = 1'b0; REQ1_h = 1'b0; D0_h = 8'h00; D1_h = 8'h00;
        tick(); tick();
        R = 1'b0; R_h = 1'b0;

        check("rst_q", Q, 8'h00);
        check("rst_ack0", ACK0, 0);
        check("rst_ack1", ACK1, 0);
        check("rst_busy", BUSY, 0);
        check("rst_last", LAST, 0);

        // Single request from reset.
        q0.push_back('{idx: 1'b0, q: 8'hA5});
        REQ0 = 1'b1; D0 = 8'hA5;
        tick();
        check("single_e0_q", Q, 8'hA5);
        check("single_e0_busy", BUSY, 1);
        REQ0 = 1'b0;
        tick();
        check("single_e1_ack0", ACK0, 0);
        check("single_e1_busy", BUSY, 1);
        tick();
        check("single_e2_busy", BUSY, 1);
        tick();
        check("single_e3_busy", BUSY, 0);

        // Continuous contention alternates 0,1,0,1 every 4 edges.
        reset0();
        REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'h11; D1 = 8'h22;
        q0.push_back('{idx: 1'b0, q: 8'h11});
        q0.push_back('{idx: 1'b1, q: 8'h22});
        q0.push_back('{idx: 1'b0, q: 8'h11});
        q0.push_back('{idx: 1'b1, q: 8'h22});
        for (int e = 0; e < 13; e++) begin
            tick();
            check("rr_ack0", ACK0, ((e % 8) == 0));
            check("rr_ack1", ACK1, ((e % 8) == 4));
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (4) tick();

        // Request arriving during lock waits for IDLE.
        reset0();
        q0.push_back('{idx: 1'b0, q: 8'h33});
        REQ0 = 1'b1; D0 = 8'h33;
        tick();
        REQ0 = 1'b0;
        tick();
        REQ1 = 1'b1; D1 = 8'h44;
        tick();
        check("lock_e2_ack1", ACK1, 0);
        tick();
        check("lock_e3_ack1", ACK1, 0);
        q0.push_back('{idx: 1'b1, q: 8'h44});
        tick();
        check("lock_e4_ack1", ACK1, 1);
        check("lock_e4_q", Q, 8'h44);
        REQ1 = 1'b0;
        repeat (4) tick();

        // Reset in the middle of lock, then PRI must favour requester 0 again.
        reset0();
        q0.push_back('{idx: 1'b0, q: 8'h55});
        REQ0 = 1'b1; D0 = 8'h55;
        tick();
        REQ0 = 1'b0;
        tick();
        R = 1'b1;
        tick();
        check("midrst_q", Q, 8'h00);
        check("midrst_busy", BUSY, 0);
        check("midrst_ack", {ACK1, ACK0}, 0);
        check("midrst_last", LAST, 0);
        R = 1'b0;
        q0.push_back('{idx: 1'b0, q: 8'h66});
        REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'h66; D1 = 8'h77;
        tick();
        check("midrst_grant0", ACK0, 1);
        REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (4) tick();

        // REQ0 present only during the ACK cycle of a requester-1 grant is lost.
        reset0();
        q0.push_back('{idx: 1'b1, q: 8'h88});
        REQ1 = 1'b1; D1 = 8'h88;
        tick();
        REQ1 = 1'b0; REQ0 = 1'b1; D0 = 8'h99;
        tick();
        check("wd_e1_ack0", ACK0, 0);
        REQ0 = 1'b0;
        for (int e = 2; e < 7; e++) begin
            tick();
            check("wd_ack0", ACK0, 0);
        end
        check("wd_q", Q, 8'h88);

        // HOLD=0 instance: back-to-back grants every 2 edges, D sampled at grant edges.
        q1.push_back('{idx: 1'b1, q: 8'h01});
        q1.push_back('{idx: 1'b1, q: 8'h03});
        q1.push_back('{idx: 1'b1, q: 8'h05});
        REQ1_h = 1'b1;
        for (int e = 0; e < 5; e++) begin
            D1_h = 8'(e + 1);
            tick();
            check("h0_ack1_pattern", ACK1_h, ((e % 2) == 0));
            check("h0_busy_pattern", BUSY_h, ((e % 2) == 0));
        end
        REQ1_h = 1'b0;
        repeat (3) tick();

        check("h2_queue_drained", q0.size(), 0);
        check("h0_queue_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
